// File: rtl/frame_scanner_pkg.sv
// frame_scanner_pkg: shared FSM states, colour constants and default raster size.
package frame_scanner_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_e;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] TRANSPARENT = 3'b000;
  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;
  // Sums are 10 bits so a sprite hanging off the right/bottom edge clips instead of wrapping.
  function automatic logic in_span(logic [8:0] p, logic [8:0] lo, int unsigned sz);
    return p >= lo && {1'b0, p} < ({1'b0, lo} + 10'(sz));
  endfunction
endpackage

// File: rtl/frame_scanner_xy_counter.sv
// xy_counter: raster x/y counter with enable, clear and last-pixel flag; holds at the last pixel.
module xy_counter #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [8:0] x_o,
  output logic [7:0] y_o,
  output logic       last_o
);
  logic [8:0] x_q;
  logic [7:0] y_q;
  logic x_end;
  assign x_end = x_q == 9'(H_RES - 1);
  assign last_o = x_end && y_q == 8'(V_RES - 1);
  assign x_o = x_q;
  assign y_o = y_q;
  always_ff @(posedge clock_i)
    if (reset_i || clr_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (en_i && !last_o) begin
      x_q <= x_end ? 9'd0 : x_q + 9'd1;
      y_q <= x_end ? y_q + 8'd1 : y_q;
    end
endmodule

// File: rtl/frame_scanner.sv
// frame_scanner: raster-scans one frame, merges background lookup with an optional sprite, drives VGA plot.
// Sprite overlay is built only when SPRITE_OVERLAY_EN is defined; cycle timing is the same either way.
module frame_scanner
  import frame_scanner_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int SPRITE_SIZE = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic [8:0] bg_x_o,
  output logic [8:0] bg_y_o,
  input  logic [2:0] bg_colour_i,
  input  logic [8:0] sprite_x_i,
  input  logic [8:0] sprite_y_i,
  input  logic [2:0] sprite_colour_i,
  output logic [8:0] x_o,
  output logic [7:0] y_o,
  output logic [2:0] colour_o,
  output logic       plot_o,
  output logic       busy_o,
  output logic       done_o
);
  state_e state_q, state_d;
  logic flush_q, flush_d, v1_q, plot_q, last, go;
  logic [8:0] x1_q, x_q;
  logic [7:0] y1_q, y_q, cy;
  logic [2:0] colour_q, colour_d;
  assign go = state_q == IDLE && start_i;
  xy_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_xy (
    .clock_i(clock_i), .reset_i(reset_i), .en_i(state_q == SCAN), .clr_i(go),
    .x_o(bg_x_o), .y_o(cy), .last_o(last)
  );
  assign bg_y_o = {1'b0, cy};
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    unique case (state_q)
      IDLE: state_d = start_i ? SCAN : IDLE;
      SCAN: state_d = last ? FLUSH : SCAN;
      FLUSH: begin
        state_d = flush_q ? DONE : FLUSH;
        flush_d = ~flush_q;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef SPRITE_OVERLAY_EN
  logic [8:0] spx_q, spy_q;
  logic [2:0] spc_q;
  logic hit;
  always_ff @(posedge clock_i)
    if (reset_i) begin
      spx_q <= '0;
      spy_q <= '0;
      spc_q <= '0;
    end else if (go) begin
      spx_q <= sprite_x_i;
      spy_q <= sprite_y_i;
      spc_q <= sprite_colour_i;
    end
  assign hit = in_span(x1_q, spx_q, SPRITE_SIZE) && in_span({1'b0, y1_q}, spy_q, SPRITE_SIZE);
  assign colour_d = (hit && spc_q != TRANSPARENT) ? spc_q : bg_colour_i;
`else
  localparam int unused_size = SPRITE_SIZE;
  logic unused_sprite;
  assign unused_sprite = ^{sprite_x_i, sprite_y_i, sprite_colour_i};
  assign colour_d = bg_colour_i;
`endif
  // Stage 1 aligns the issued coordinate with the lookup result; stage 2 is the VGA output register.
  always_ff @(posedge clock_i)
    if (reset_i) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
      v1_q <= 1'b0;
      x1_q <= '0;
      y1_q <= '0;
      plot_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      v1_q <= state_q == SCAN;
      x1_q <= bg_x_o;
      y1_q <= cy;
      plot_q <= v1_q;
      x_q <= x1_q;
      y_q <= y1_q;
      colour_q <= colour_d;
    end
  assign plot_o = plot_q;
  assign x_o = x_q;
  assign y_o = y_q;
  assign colour_o = colour_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
endmodule

// File: tb/tb_frame_scanner.sv
// tb_frame_scanner: small-raster frame checks against a pixel-level reference model plus probe table.
module tb_frame_scanner;
  localparam int H = 24;
  localparam int V = 10;
  localparam int SZ = 8;
  localparam int N = H * V;
`ifdef SPRITE_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  logic clk = 1'b0, rst, start;
  logic [8:0] bg_x, bg_y, sprite_x, sprite_y, x;
  logic [7:0] y;
  logic [2:0] bg_colour, sprite_colour, colour;
  logic plot, busy, done;
  int checks = 0, failures = 0;
  logic [2:0] cap [N];

  frame_scanner #(.H_RES(H), .V_RES(V), .SPRITE_SIZE(SZ)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .bg_x_o(bg_x), .bg_y_o(bg_y),
    .bg_colour_i(bg_colour), .sprite_x_i(sprite_x), .sprite_y_i(sprite_y),
    .sprite_colour_i(sprite_colour), .x_o(x), .y_o(y), .colour_o(colour),
    .plot_o(plot), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] bgf(int px, int py);
    return 3'(px * 3 + py * 5 + 1);
  endfunction

  always @(posedge clk) bg_colour <= bgf(int'(bg_x), int'(bg_y));

  function automatic logic [2:0] model(int px, int py, int sx, int sy, int sc);
    bit hit;
    hit = px >= sx && px < sx + SZ && py >= sy && py < sy + SZ;
    return (OVL && hit && sc != 0) ? 3'(sc) : bgf(px, py);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is just after a negedge with the DUT idle; this cycle is cycle 0. Ends in cycle N+4.
  task automatic frame(input int sx, input int sy, input int sc, input bit disturb, input bit hold);
    int bad_pix = 0, plots = 0, dones = 0, done_at = -1, bad_busy = 0, k;
    sprite_x = 9'(sx);
    sprite_y = 9'(sy);
    sprite_colour = 3'(sc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bg_origin", {bg_x, bg_y}, 32'd0);
    for (int c = 1; c <= N + 4; c++) begin
      if (plot === 1'b1) begin
        plots++;
        k = c - 3;
        if (c < 3 || c > N + 2) bad_pix++;
        else begin
          if (x !== 9'(k % H) || y !== 8'(k / H) || colour !== model(k % H, k / H, sx, sy, sc)) bad_pix++;
          cap[k] = colour;
        end
      end else if (c >= 3 && c <= N + 2) bad_pix++;
      if (done === 1'b1) begin
        dones++;
        done_at = c;
      end
      if (busy !== (c <= N + 3)) bad_busy++;
      if (disturb && c == N / 2) begin
        start = 1'b1;
        sprite_x = sprite_x + 9'd37;
        sprite_colour = ~sprite_colour;
      end
      if (disturb && c == N / 2 + 1) start = 1'b0;
      if (hold && c == N + 3) start = 1'b1;
      if (c < N + 4) @(negedge clk);
    end
    chk("bad_pixels", bad_pix, 0);
    chk("plot_count", plots, N);
    chk("done_count", dones, 1);
    chk("done_cycle", done_at, N + 3);
    chk("busy_cycles", bad_busy, 0);
  endtask

  typedef struct {int sx, sy, sc, px, py; bit use_bg; logic [2:0] c;} probe_t;
  probe_t tbl [13];

  initial begin
    logic [2:0] ec;
    tbl[0]  = '{5, 2, 4, 5, 2, 1'b0, 3'd4};
    tbl[1]  = '{5, 2, 4, 12, 9, 1'b0, 3'd4};
    tbl[2]  = '{5, 2, 4, 13, 2, 1'b1, 3'd0};
    tbl[3]  = '{5, 2, 4, 4, 9, 1'b1, 3'd0};
    tbl[4]  = '{5, 2, 4, 12, 1, 1'b1, 3'd0};
    tbl[5]  = '{20, 6, 1, 20, 6, 1'b0, 3'd1};
    tbl[6]  = '{20, 6, 1, 23, 9, 1'b0, 3'd1};
    tbl[7]  = '{20, 6, 1, 0, 6, 1'b1, 3'd0};
    tbl[8]  = '{20, 6, 1, 3, 9, 1'b1, 3'd0};
    tbl[9]  = '{20, 6, 1, 19, 9, 1'b1, 3'd0};
    tbl[10] = '{20, 6, 1, 20, 5, 1'b1, 3'd0};
    tbl[11] = '{5, 2, 0, 5, 2, 1'b1, 3'd0};
    tbl[12] = '{5, 2, 0, 9, 6, 1'b1, 3'd0};
    rst = 1'b1;
    start = 1'b0;
    sprite_x = '0;
    sprite_y = '0;
    sprite_colour = '0;
    repeat (3) @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xyc", {x, y, colour}, 0);
    chk("rst_bg", {bg_x, bg_y}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 13; i++) begin
      if (i == 0 || tbl[i].sx != tbl[i-1].sx || tbl[i].sy != tbl[i-1].sy || tbl[i].sc != tbl[i-1].sc) begin
        frame(tbl[i].sx, tbl[i].sy, tbl[i].sc, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
      end
      ec = (tbl[i].use_bg || !OVL) ? bgf(tbl[i].px, tbl[i].py) : tbl[i].c;
      chk($sformatf("probe%0d", i), cap[tbl[i].py * H + tbl[i].px], ec);
    end
    for (int r = 0; r < 4; r++) begin
      frame(int'($urandom_range(0, H + 4)), int'($urandom_range(0, V + 2)), int'($urandom_range(0, 7)), 1'b0, 1'b0);
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end
    frame(7, 1, 6, 1'b1, 1'b0);
    @(negedge clk);
    frame(20, 6, 1, 1'b0, 1'b1);
    frame(3, 3, 5, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    sprite_colour = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 3 * N && !(bg_x == 9'd10 && bg_y == 9'd5); t++) @(negedge clk);
    chk("reach_10_5", {bg_x, bg_y}, {9'd10, 9'd5});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bg", {bg_x, bg_y}, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_idle", {busy, plot, done}, 0);
    frame(0, 0, 3, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_scanner.md
FRAME_SCANNER -- requirements
Module: frame_scanner

Interface
REQ-001 Parameter H_RES, default 320, pixels per line.
REQ-002 Parameter V_RES, default 240, lines per frame.
REQ-003 Parameter SPRITE_SIZE, default 8, sprite edge length in pixels.
REQ-004 clock  input  1  single system clock; all logic SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to render one frame; sampled only in IDLE.
REQ-007 bg_x, bg_y  output  9 each  coordinate presented to the background colour lookup.
REQ-008 bg_colour  input  3  lookup colour, valid exactly one cycle after bg_x/bg_y.
REQ-009 sprite_x, sprite_y  input  9 each  sprite top-left corner.
REQ-010 sprite_colour  input  3  sprite colour; 3'b000 means transparent.
REQ-011 x  output  9  pixel x to the VGA adapter.
REQ-012 y  output  8  pixel y to the VGA adapter.
REQ-013 colour  output  3  pixel colour to the VGA adapter.
REQ-014 plot  output  1  write strobe; x/y/colour are valid while high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-017 FSM states: IDLE, SCAN, FLUSH, DONE.
- IDLE->SCAN on start.
- SCAN->FLUSH after the last coordinate is issued.
- FLUSH->DONE after 2 cycles.
- DONE->IDLE unconditionally.
REQ-018 SCAN SHALL issue one coordinate per cycle in raster order: x 0..H_RES-1 (inner loop), then y 0..V_RES-1; x wraps to 0 as y increments.
REQ-019 The coordinate issued in cycle n SHALL drive plot/x/y/colour, registered, in cycle n+2.
REQ-020 Timing relative to start sampled in cycle 0:
- bg (0,0) is issued in cycle 1.
- plot is high in cycles 3..H_RES*V_RES+2 inclusive and low at all other times.
- done is high in cycle H_RES*V_RES+3 only.
REQ-021 start SHALL be ignored while busy; a start held high through DONE SHALL begin a new frame from IDLE on the next cycle.
REQ-022 bg_x/bg_y SHALL hold their last value outside SCAN.
REQ-023 Sprite hit test: pixel (px,py) is a hit when sprite_x <= px < sprite_x+SPRITE_SIZE and sprite_y <= py < sprite_y+SPRITE_SIZE.
- Sums SHALL be computed 10 bits wide, so a sprite overlapping the right or bottom edge clips without wrap-around.
REQ-024 Output colour SHALL be sprite_colour on a hit with a nonzero sprite_colour, and bg_colour otherwise.
REQ-025 sprite_x/y/colour SHALL be latched on the start acceptance cycle; changes during a frame have no effect until the next frame.

Reset
REQ-026 When reset is high at a clock edge, the block SHALL return to IDLE, regardless of state and including mid-frame.
REQ-027 Reset SHALL clear: plot, done and busy to 0; x, y, bg_x, bg_y and colour to 0; sprite latches to 0.
REQ-028 The first start after reset deasserts SHALL render a full frame from (0,0).

Configuration
REQ-029 Macro SPRITE_OVERLAY_EN:
- Defined: REQ-023..REQ-025 are implemented.
- Undefined: colour always equals the delayed bg_colour, the sprite inputs are unused, and no sprite latches exist.
- Cycle timing is identical in both builds.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state enum;
- the colour constants (BLACK=000, GREEN=010, WHITE=111, TRANSPARENT=000);
- the default H_RES/V_RES.
REQ-031 One sub-module, xy_counter, SHALL provide the raster x/y counter with enable, clear and last-pixel flag.
- The background lookup is external and not instantiated here.

Verification
REQ-032 Stimulus: reset, start pulse, bg_colour stub = registered f(x,y).
- Expect exactly 76800 plot cycles in raster order, each colour = f of its coordinate.
- Expect done in cycle 76803.
REQ-033 Stimulus: sprite at (100,50), colour 3'b100.
- Expect pixels x 100..107, y 50..57 plotted as 100; (108,50) and (99,57) show bg_colour.
REQ-034 Stimulus: sprite at (316,236), colour 3'b001.
- Expect only x 316..319, y 236..239 overridden.
- Expect no writes at x 0..3 (no wrap).
REQ-035 Stimulus: sprite colour 3'b000.
- Expect the frame identical to the background-only frame.
REQ-036 Stimulus: reset at SCAN pixel (150,90).
- Expect plot low and busy low next cycle.
- A new start SHALL restart at (0,0).
REQ-037 Stimulus: start re-pulsed mid-frame, and sprite_x changed mid-frame.
- Expect no restart, the original sprite position retained, and a single done.
